rd_arb_non2n: RTL

Round-robin read-port arbiter for the non-power-of-2 asynchronous FIFO. It shares the single FIFO read port between NUM_REQ consumers and sequences bounded read bursts. It drives `r_en` into the read-pointer handler and steers the returned memory word to the granted consumer. It sits entirely in the rclk domain, between the FIFO read side and the consumer blocks.

---
 rtl/rd_arb_non2n_if.sv | 26 ++
 rtl/rd_arb_non2n.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rd_arb_non2n_if.sv
// Read-side bus between the FIFO/consumers and rd_arb_non2n.
// Protocol: r_en is a read strobe, with no back-pressure. rdata is valid the cycle after r_en.
// A one-hot dout_valid marks the consumer that owns dout in that cycle.
interface rd_arb_non2n_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]    req;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  r_en;
  logic [NUM_REQ-1:0]    gnt;
  logic [DATA_WIDTH-1:0] dout;
  logic [NUM_REQ-1:0]    dout_valid;
  logic                  burst_done;

  modport master (
    input  req, empty, rdata,
    output r_en, gnt, dout, dout_valid, burst_done
  );

  modport slave (
    output req, empty, rdata,
    input  r_en, gnt, dout, dout_valid, burst_done
  );
endinterface

// File: rtl/rd_arb_non2n.sv
// Round-robin read-port arbiter with a 2-cycle return path.
// Macro RD_ARB_BURST_EN enables bursts of up to MAX_BURST reads; without it, every grant performs one read.
module rd_arb_non2n #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic           rclk,
   input  logic           rrst_n,
   rd_arb_non2n_if.master bus,
   output logic [0:0]     dbg_state_o
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;
`ifdef RD_ARB_BURST_EN
   localparam int MB = MAX_BURST;
   localparam int CW = $clog2(MB + 1);
`else
   localparam int MB = 1 + 0 * MAX_BURST;
`endif

   logic [0:0]            state_q, state_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d;
   logic                  done_q, done_d;
   logic                  ren_d1_q;
   logic [IW-1:0]         own_d1_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic [NUM_REQ-1:0]    dv_q;
`ifdef RD_ARB_BURST_EN
   logic [CW-1:0]         cnt_q, cnt_d;
`endif

   logic          found;
   logic [IW-1:0] sel_idx;
   logic [IW-1:0] kk;
   int            k;
   logic          req_own, room, last_rd, r_en, release_now;
   logic [IW-1:0] nxt_ptr;

   // Cyclic search starting at the priority pointer.
   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      k       = 0;
      kk      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k  = (int'(ptr_q) + i) % NUM_REQ;
         kk = IW'(k);
         if (!found && bus.req[kk]) begin
            found   = 1'b1;
            sel_idx = kk;
         end
      end
   end

`ifdef RD_ARB_BURST_EN
   assign room    = (int'(cnt_q) < MB);
   assign last_rd = (int'(cnt_q) == MB - 1);
`else
   assign room    = 1'b1;
   assign last_rd = (MB == 1);
`endif

   assign req_own     = bus.req[owner_q];
   assign r_en        = (state_q == ST_BURST) & req_own & ~bus.empty & room;
   assign release_now = (r_en & last_rd) | ~req_own;
   assign nxt_ptr     = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      done_d  = 1'b0;
`ifdef RD_ARB_BURST_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d = ST_BURST;
               owner_d = sel_idx;
               gnt_d   = NUM_REQ'(1) << sel_idx;
`ifdef RD_ARB_BURST_EN
               cnt_d   = '0;
`endif
            end
         end
         default: begin
`ifdef RD_ARB_BURST_EN
            if (r_en) cnt_d = cnt_q + 1'b1;
`endif
            if (release_now) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               ptr_d   = nxt_ptr;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         ptr_q    <= '0;
         gnt_q    <= '0;
         done_q   <= 1'b0;
         ren_d1_q <= 1'b0;
         own_d1_q <= '0;
         dout_q   <= '0;
         dv_q     <= '0;
`ifdef RD_ARB_BURST_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         ren_d1_q <= r_en;
         own_d1_q <= owner_q;
`ifdef RD_ARB_BURST_EN
         cnt_q    <= cnt_d;
`endif
         // The return path runs independently of the grant, so words read late in a burst still land after release.
         if (ren_d1_q) begin
            dout_q <= bus.rdata;
            dv_q   <= NUM_REQ'(1) << own_d1_q;
         end else begin
            dv_q   <= '0;
         end
      end
   end

   assign bus.r_en       = r_en;
   assign bus.gnt        = gnt_q;
   assign bus.burst_done = done_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dv_q;
   assign dbg_state_o    = state_q;
endmodule
